countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Loadable down-counter/timer: the counterpart of the team's `counter` up-counter; counts a programmed value down to zero.
- Decrements by STEP on each enabled tick while running.
- Emits a one-cycle `done` pulse at terminal count; optionally auto-reloads for periodic operation.
- Used as a timeout/interval source by control FSMs; sits beside `counter` in the shared utility layer.

Parameters:
- DATA_WIDTH, 8, width of `count`, `load_val` and the reload register.
- STEP, 1, decrement per enabled tick; must satisfy 1 <= STEP <= 2^DATA_WIDTH-1.
- PRESCALE, 4, ticks of `en` per decrement; power of two >= 2; only used with COUNTDOWN_PRESCALE_EN.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- load  in  1  capture `load_val` into `count` and the reload register.
- load_val  in  DATA_WIDTH  start/reload value.
- start  in  1  begin or resume countdown.
- stop  in  1  pause countdown and hold `count`.
- en  in  1  tick enable; decrement only when high.
- auto_reload  in  1  on terminal count, reload and keep running.
- count  out  DATA_WIDTH  current value, registered.
- busy  out  1  high while state == RUN, decoded from the state register.
- done  out  1  registered one-cycle pulse at terminal count.

Behaviour:
- Reset (rst low, asynchronous assert, synchronous release):
  - count = 0, reload register = 0, state = IDLE, busy = 0, done = 0.
  - Prescaler cleared.
- States: IDLE, RUN. `done` defaults to 0 every cycle unless set by a rule below.
- Priority per cycle: load > stop > start > tick.
- load (any state):
  - count <= load_val; reload <= load_val; state <= IDLE.
  - No done. An in-progress countdown is aborted.
- stop in RUN:
  - state <= IDLE; count held; no done.
  - This holds even when the same cycle would have been a terminal tick.
- start in IDLE:
  - count != 0: state <= RUN; busy is high from the next cycle.
  - count == 0: stays IDLE; done pulses next cycle.
- start in RUN: ignored.
- Tick = RUN and en (gated further by the prescaler if enabled).
  - Non-terminal tick (count > STEP): count <= count - STEP.
  - Terminal tick (count <= STEP, i.e. count - STEP would be <= 0):
    - done <= 1 for exactly one cycle. The count value after this edge is defined by the next two rules.
    - auto_reload high and reload != 0: count <= reload; state stays RUN.
    - Otherwise: count <= 0; state <= IDLE.
- No underflow wrap: the subtraction result is never negative; terminal detection is by unsigned compare `count <= STEP`.
- Period with auto_reload: ceil(reload/STEP) ticks between done pulses. done pulses are never back-to-back unless the period is 1 tick.
- en low in RUN: count held; no done.
- auto_reload is sampled only at the terminal tick.
- rst asserted mid-count: immediate return to reset values; no done.

Optional Feature:
- COUNTDOWN_PRESCALE_EN defined:
  - A log2(PRESCALE)-bit prescaler increments on each RUN and en cycle.
  - Tick asserts only when the prescaler is all-ones and en is high; the prescaler then wraps to 0.
  - Prescaler cleared on reset, load and start.
- COUNTDOWN_PRESCALE_EN not defined: tick = RUN and en; PRESCALE is ignored; no prescaler flops exist.

Decomposition:
- Shared package `counter_pkg`: `timer_state_t` enum (IDLE, RUN) and a `clog2`-based width helper constant for the prescaler.
- One sub-module, `countdown_prescaler`: the power-of-two tick divider, compiled only under COUNTDOWN_PRESCALE_EN.
- All other logic lives in the top module.

Test Plan:
- Reset, then load_val=5, STEP=1, start, en held high → count 4,3,2,1,0 on successive cycles; done high only in the cycle count becomes 0; busy falls the same cycle.
- load_val=10, STEP=3, auto_reload=1, en high → count 7,4,1, then 10 with done pulse; pattern repeats with a period of 4 ticks.
- load_val=6, start, en toggling 1,0,1,0 → count decrements only on en-high cycles; done after 6 enabled ticks.
- Stop at count=3, then start 2 cycles later → count holds 3 while IDLE; resumes 2,1,0. Separately, stop coinciding with the terminal tick → no done; count holds 1.
- Load while RUN at count=4 with load_val=9 → state IDLE, count 9, no done. Separately, start with count=0 → one done pulse, busy stays 0.
- With COUNTDOWN_PRESCALE_EN, PRESCALE=4, load_val=2, en high → count decrements every 4th cycle; done at cycle 8 after start.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and helpers for the counter/timer utility layer.
package counter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } timer_state_t;

   localparam int PRESCALE_DEFAULT = 4;

   // Prescaler register width; a divide-by-2 still needs one flop.
   function automatic int presc_width(input int prescale);
      return (prescale > 2) ? $clog2(prescale) : 1;
   endfunction

   localparam int PRESC_W_DEFAULT = presc_width(PRESCALE_DEFAULT);

endpackage

// File: rtl/countdown_prescaler.sv
// Power-of-two tick divider: passes every PRESCALE-th enabled cycle as a tick.
module countdown_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = PRESCALE_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic cnt_en_i,
   output logic tick_o
);

   localparam int W = presc_width(PRESCALE);

   logic [W-1:0] presc_q;
   logic [W-1:0] presc_d;

   always_comb begin
      presc_d = presc_q;
      if (clr_i) begin
         presc_d = '0;
      end else if (cnt_en_i) begin
         presc_d = presc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   assign tick_o = cnt_en_i & (&presc_q);

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload.
// Define COUNTDOWN_PRESCALE_EN to divide the en tick rate by PRESCALE.
module countdown_timer
   import counter_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int STEP       = 1,
   parameter int PRESCALE   = PRESCALE_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_val,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  en,
   input  logic                  auto_reload,
   output logic [DATA_WIDTH-1:0] count,
   output logic                  busy,
   output logic                  done
);

   localparam logic [DATA_WIDTH-1:0] STEP_V = DATA_WIDTH'(STEP);

   timer_state_t          state_q, state_d;
   logic [DATA_WIDTH-1:0] count_q, count_d;
   logic [DATA_WIDTH-1:0] reload_q, reload_d;
   logic                  done_q, done_d;
   logic                  run_en;
   logic                  tick;

   assign run_en = (state_q == RUN) & en;

`ifdef COUNTDOWN_PRESCALE_EN
   countdown_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk      (clk),
      .rst_n    (rst),
      .clr_i    (load | start),
      .cnt_en_i (run_en),
      .tick_o   (tick)
   );
`else
   assign tick = run_en;
`endif

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      if (load) begin
         count_d  = load_val;
         reload_d = load_val;
         state_d  = IDLE;
      end else if (stop) begin
         state_d = IDLE;
      end else if (start && (state_q == IDLE)) begin
         // Starting an expired timer reports completion instead of running.
         if (count_q != '0) begin
            state_d = RUN;
         end else begin
            done_d = 1'b1;
         end
      end else if (tick) begin
         if (count_q <= STEP_V) begin
            done_d = 1'b1;
            if (auto_reload && (reload_q != '0)) begin
               count_d = reload_q;
            end else begin
               count_d = '0;
               state_d = IDLE;
            end
         end else begin
            count_d = count_q - STEP_V;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

   assign count = count_q;
   assign busy  = (state_q == RUN);
   assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (STEP=1, STEP=3) against an integer reference model.
module tb_countdown_timer;

   localparam int STEP_A = 1;
   localparam int STEP_B = 3;
`ifdef COUNTDOWN_PRESCALE_EN
   localparam int PRESC = 4;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'd0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       en = 1'b0;
   logic       auto_reload = 1'b0;
   logic [7:0] cnt [2];
   logic [1:0] busy;
   logic [1:0] dn;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int unsigned m_count [2];
   int unsigned m_reload [2];
   bit          m_run [2];
   bit          m_done [2];
`ifdef COUNTDOWN_PRESCALE_EN
   int unsigned m_pc [2];
`endif

   always #5 clk = ~clk;

   countdown_timer #(.DATA_WIDTH(8), .STEP(STEP_A), .PRESCALE(4)) u_dut_a (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
      .stop(stop), .en(en), .auto_reload(auto_reload),
      .count(cnt[0]), .busy(busy[0]), .done(dn[0])
   );

   countdown_timer #(.DATA_WIDTH(8), .STEP(STEP_B), .PRESCALE(4)) u_dut_b (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .start(start),
      .stop(stop), .en(en), .auto_reload(auto_reload),
      .count(cnt[1]), .busy(busy[1]), .done(dn[1])
   );

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_count[i]  = 0;
         m_reload[i] = 0;
         m_run[i]    = 1'b0;
         m_done[i]   = 1'b0;
`ifdef COUNTDOWN_PRESCALE_EN
         m_pc[i]     = 0;
`endif
      end
   endtask

   // One clock of the timer, described as integer arithmetic on the rules.
   task automatic model_step();
      int s;
      int rem;
      bit tk;
      for (int i = 0; i < 2; i++) begin
         s  = (i == 0) ? STEP_A : STEP_B;
         tk = m_run[i] && en;
`ifdef COUNTDOWN_PRESCALE_EN
         tk = tk && (m_pc[i] == PRESC - 1);
         if (load || start) m_pc[i] = 0;
         else if (m_run[i] && en) m_pc[i] = (m_pc[i] + 1) % PRESC;
`endif
         m_done[i] = 1'b0;
         if (load) begin
            m_count[i]  = load_val;
            m_reload[i] = load_val;
            m_run[i]    = 1'b0;
         end else if (stop) begin
            m_run[i] = 1'b0;
         end else if (start && !m_run[i]) begin
            if (m_count[i] != 0) m_run[i] = 1'b1;
            else m_done[i] = 1'b1;
         end else if (tk) begin
            rem = int'(m_count[i]) - s;
            if (rem <= 0) begin
               m_done[i] = 1'b1;
               if (auto_reload && m_reload[i] != 0) begin
                  m_count[i] = m_reload[i];
               end else begin
                  m_count[i] = 0;
                  m_run[i]   = 1'b0;
               end
            end else begin
               m_count[i] = rem;
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      $display("cyc %0d ld=%b lv=%0d st=%b sp=%b en=%b ar=%b | A cnt=%0d busy=%b done=%b | B cnt=%0d busy=%b done=%b",
               cyc, load, load_val, start, stop, en, auto_reload,
               cnt[0], busy[0], dn[0], cnt[1], busy[1], dn[1]);
   endtask

   task automatic set_in(bit l, int lv, bit st, bit sp, bit e, bit ar);
      load = l; load_val = 8'(lv); start = st; stop = sp; en = e; auto_reload = ar;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (cnt[i] !== 8'd0 || busy[i] !== 1'b0 || dn[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset dut%0d: count=%0d busy=%b done=%b, expected 0/0/0", i, cnt[i], busy[i], dn[i]);
         end
      end
      #3 rst = 1'b1;
   endtask

   task automatic test_basic();
      int exp_a [5] = '{4, 3, 2, 1, 0};
      set_in(1, 5, 0, 0, 0, 0); cycle();
      set_in(0, 0, 1, 0, 1, 0); cycle();
      set_in(0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 8; k++) begin
         cycle();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (cnt[i] !== 8'(m_count[i]) || busy[i] !== m_run[i] || dn[i] !== m_done[i]) begin
               errors++;
               $display("FAIL basic dut%0d: count=%0d busy=%b done=%b, expected %0d/%b/%b",
                        i, cnt[i], busy[i], dn[i], m_count[i], m_run[i], m_done[i]);
            end
         end
`ifndef COUNTDOWN_PRESCALE_EN
         if (k < 5) begin
            checks++;
            if (cnt[0] !== 8'(exp_a[k]) || dn[0] !== (k == 4) || busy[0] !== (k != 4)) begin
               errors++;
               $display("FAIL basic_seq step %0d: count=%0d done=%b busy=%b, expected %0d/%b/%b",
                        k, cnt[0], dn[0], busy[0], exp_a[k], (k == 4), (k != 4));
            end
         end
`endif
      end
   endtask

   task automatic test_auto_reload();
      int exp_b [8] = '{7, 4, 1, 10, 7, 4, 1, 10};
      set_in(1, 10, 0, 0, 0, 1); cycle();
      set_in(0, 0, 1, 0, 1, 1); cycle();
      set_in(0, 0, 0, 0, 1, 1);
      for (int k = 0; k < 24; k++) begin
         if (k == 20) auto_reload = 1'b0;
         cycle();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (cnt[i] !== 8'(m_count[i]) || busy[i] !== m_run[i] || dn[i] !== m_done[i]) begin
               errors++;
               $display("FAIL auto_reload dut%0d: count=%0d busy=%b done=%b, expected %0d/%b/%b",
                        i, cnt[i], busy[i], dn[i], m_count[i], m_run[i], m_done[i]);
            end
         end
`ifndef COUNTDOWN_PRESCALE_EN
         if (k < 8) begin
            checks++;
            if (cnt[1] !== 8'(exp_b[k]) || dn[1] !== (k % 4 == 3)) begin
               errors++;
               $display("FAIL reload_seq step %0d: count=%0d done=%b, expected %0d/%b",
                        k, cnt[1], dn[1], exp_b[k], (k % 4 == 3));
            end
         end
`endif
      end
   endtask

   task automatic test_en_toggle();
      set_in(1, 6, 0, 0, 0, 0); cycle();
      set_in(0, 0, 1, 0, 0, 0); cycle();
      for (int k = 0; k < 16; k++) begin
         set_in(0, 0, 0, 0, (k % 2 == 0), 0);
         cycle();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (cnt[i] !== 8'(m_count[i]) || busy[i] !== m_run[i] || dn[i] !== m_done[i]) begin
               errors++;
               $display("FAIL en_toggle dut%0d: count=%0d busy=%b done=%b, expected %0d/%b/%b",
                        i, cnt[i], busy[i], dn[i], m_count[i], m_run[i], m_done[i]);
            end
         end
      end
   endtask

   task automatic test_stop_resume();
      bit sp;
      bit st;
      set_in(1, 6, 0, 0, 0, 0); cycle();
      set_in(0, 0, 1, 0, 1, 0); cycle();
      for (int k = 0; k < 10; k++) begin
         sp = (k == 3);
         st = (k == 6);
         set_in(0, 0, st, sp, 1, 0);
         cycle();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (cnt[i] !== 8'(m_count[i]) || busy[i] !== m_run[i] || dn[i] !== m_done[i]) begin
               errors++;
               $display("FAIL stop_resume dut%0d: count=%0d busy=%b done=%b, expected %0d/%b/%b",
                        i, cnt[i], busy[i], dn[i], m_count[i], m_run[i], m_done[i]);
            end
         end
`ifndef COUNTDOWN_PRESCALE_EN
         if (k == 5) begin
            checks++;
            if (cnt[0] !== 8'd3 || busy[0] !== 1'b0) begin
               errors++;
               $display("FAIL stop_hold: count=%0d busy=%b, expected 3/0", cnt[0], busy[0]);
            end
         end
`endif
      end
      // Stop landing on what would have been the terminal tick.
      set_in(1, 2, 0, 0, 0, 0); cycle();
      set_in(0, 0, 1, 0, 1, 0); cycle();
      set_in(0, 0, 0, 0, 1, 0); cycle();
      set_in(0, 0, 0, 1, 1, 0); cycle();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (cnt[i] !== 8'(m_count[i]) || busy[i] !== m_run[i] || dn[i] !== m_done[i]) begin
            errors++;
            $display("FAIL stop_terminal dut%0d: count=%0d busy=%b done=%b, expected %0d/%b/%b",
                     i, cnt[i], busy[i], dn[i], m_count[i], m_run[i], m_done[i]);
         end
      end
`ifndef COUNTDOWN_PRESCALE_EN
      checks++;
      if (cnt[0] !== 8'd1 || dn[0] !== 1'b0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL stop_terminal_const: count=%0d done=%b busy=%b, expected 1/0/0", cnt[0], dn[0], busy[0]);
      end
`endif
   endtask

   task automatic test_load_abort();
      set_in(1, 8, 0, 0, 0, 0); cycle();
      set_in(0, 0, 1, 0, 1, 0); cycle();
      set_in(0, 0, 0, 0, 1, 0);
      repeat (4) cycle();
      set_in(1, 9, 0, 0, 1, 0); cycle();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (cnt[i] !== 8'd9 || busy[i] !== 1'b0 || dn[i] !== 1'b0) begin
            errors++;
            $display("FAIL load_abort dut%0d: count=%0d busy=%b done=%b, expected 9/0/0", i, cnt[i], busy[i], dn[i]);
         end
      end
      set_in(1, 0, 0, 0, 1, 0); cycle();
      set_in(0, 0, 1, 0, 1, 0); cycle();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (cnt[i] !== 8'd0 || busy[i] !== 1'b0 || dn[i] !== 1'b1) begin
            errors++;
            $display("FAIL start_zero dut%0d: count=%0d busy=%b done=%b, expected 0/0/1", i, cnt[i], busy[i], dn[i]);
         end
      end
      set_in(0, 0, 0, 0, 1, 0); cycle();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (dn[i] !== 1'b0 || busy[i] !== 1'b0) begin
            errors++;
            $display("FAIL start_zero_pulse dut%0d: done=%b busy=%b, expected 0/0", i, dn[i], busy[i]);
         end
      end
   endtask

`ifdef COUNTDOWN_PRESCALE_EN
   task automatic test_prescale();
      set_in(1, 2, 0, 0, 0, 0); cycle();
      set_in(0, 0, 1, 0, 1, 0); cycle();
      set_in(0, 0, 0, 0, 1, 0);
      for (int k = 1; k <= 10; k++) begin
         cycle();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (cnt[i] !== 8'(m_count[i]) || busy[i] !== m_run[i] || dn[i] !== m_done[i]) begin
               errors++;
               $display("FAIL prescale dut%0d: count=%0d busy=%b done=%b, expected %0d/%b/%b",
                        i, cnt[i], busy[i], dn[i], m_count[i], m_run[i], m_done[i]);
            end
         end
         checks++;
         if (dn[0] !== (k == 8)) begin
            errors++;
            $display("FAIL prescale_done cycle %0d: done=%b, expected %b", k, dn[0], (k == 8));
         end
      end
   endtask
`endif

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         set_in(($urandom_range(0, 19) == 0), $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 20),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1);
         cycle();
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (cnt[i] !== 8'(m_count[i]) || busy[i] !== m_run[i] || dn[i] !== m_done[i]) begin
               errors++;
               $display("FAIL random dut%0d cyc %0d: count=%0d busy=%b done=%b, expected %0d/%b/%b",
                        i, cyc, cnt[i], busy[i], dn[i], m_count[i], m_run[i], m_done[i]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      set_in(1, 50, 0, 0, 0, 1); cycle();
      set_in(0, 0, 1, 0, 1, 1); cycle();
      set_in(0, 0, 0, 0, 1, 1);
      repeat (3) cycle();
      #2 rst = 1'b0;
      #1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (cnt[i] !== 8'd0 || busy[i] !== 1'b0 || dn[i] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset dut%0d: count=%0d busy=%b done=%b, expected 0/0/0", i, cnt[i], busy[i], dn[i]);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      set_in(0, 0, 0, 0, 1, 1);
      repeat (2) cycle();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (cnt[i] !== 8'd0 || busy[i] !== 1'b0 || dn[i] !== 1'b0) begin
            errors++;
            $display("FAIL post_reset dut%0d: count=%0d busy=%b done=%b, expected 0/0/0", i, cnt[i], busy[i], dn[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_auto_reload();
      test_en_toggle();
      test_stop_resume();
      test_load_abort();
`ifdef COUNTDOWN_PRESCALE_EN
      test_prescale();
`endif
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
